// File: rtl/ex_mem_skid_pkg.sv
// ex_pkg: shared state encoding and default widths for the EX/MEM skid stage
package ex_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_RD_W = 5;
  localparam int DEF_CNT_W = 8;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  // slot vector is packed as {trap, we, rd, res}
  function automatic int slot_w(input int width, input int rd_w);
    return width + rd_w + 2;
  endfunction
endpackage

// File: rtl/ex_mem_skid_if.sv
// ex_mem_skid_if: ALU-side, memory-side and status signals of the EX/MEM boundary
interface ex_mem_skid_if
  import ex_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RD_W = DEF_RD_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_res;
  logic in_ovf;
  logic in_ovf_en;
  logic [RD_W-1:0] in_rd;
  logic in_we;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_res;
  logic [RD_W-1:0] out_rd;
  logic out_we;
  logic out_trap;
  logic ovf_sticky;
  logic [CNT_W-1:0] ovf_count;
  logic ovf_clr;
  modport slave (
    input in_valid, in_res, in_ovf, in_ovf_en, in_rd, in_we, flush, out_ready, ovf_clr,
    output in_ready, out_valid, out_res, out_rd, out_we, out_trap, ovf_sticky, ovf_count
  );
  modport master (
    output in_valid, in_res, in_ovf, in_ovf_en, in_rd, in_we, flush, out_ready, ovf_clr,
    input in_ready, out_valid, out_res, out_rd, out_we, out_trap, ovf_sticky, ovf_count
  );
endinterface

// File: rtl/ex_mem_skid_pipe_slot.sv
// pipe_slot: one payload register with load enable, async reset to zero
module pipe_slot #(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_q, data_d;
  always_comb data_d = ld ? d : data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else data_q <= data_d;
  assign q = data_q;
endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX/MEM boundary with two-entry skid buffer, overflow trap capture
// and sticky/saturating overflow status.
module ex_mem_skid
  import ex_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RD_W = DEF_RD_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  ex_mem_skid_if.slave bus
);
  localparam int SW = slot_w(WIDTH, RD_W);
  logic [1:0] state_q, state_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0] cap, main_d, main_q, skid_q;
  logic main_ld, skid_ld, in_fire, out_fire, ret_trap;
  assign in_fire = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;
  // x0 never gets written; stale overflow from non-add/sub ops is masked
  assign cap = {bus.in_ovf & bus.in_ovf_en, bus.in_we & (|bus.in_rd), bus.in_rd, bus.in_res};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      sticky_q <= sticky_d;
      cnt_q <= cnt_d;
    end
  always_comb
    state_d = bus.flush ? ST_EMPTY :
              state_q == ST_EMPTY ? (in_fire ? ST_ONE : ST_EMPTY) :
              state_q == ST_ONE ? (in_fire && !out_fire ? ST_FULL :
                                   !in_fire && out_fire ? ST_EMPTY : ST_ONE) :
              out_fire ? ST_ONE : ST_FULL;
  // handshake flags are registered from the next state so they stay pure flop outputs
  always_comb begin
    in_ready_d = state_d != ST_FULL;
    out_valid_d = state_d != ST_EMPTY;
    main_ld = !bus.flush && ((state_q == ST_EMPTY && in_fire) ||
                             (state_q == ST_ONE && in_fire && out_fire) ||
                             (state_q == ST_FULL && out_fire));
    skid_ld = !bus.flush && state_q == ST_ONE && in_fire && !out_fire;
    main_d = state_q == ST_FULL ? skid_q : cap;
  end
  always_comb begin
    ret_trap = out_fire & main_q[SW-1] & !bus.flush;
    sticky_d = bus.ovf_clr ? ret_trap : sticky_q | ret_trap;
    cnt_d = bus.ovf_clr ? {{(CNT_W-1){1'b0}}, ret_trap} :
            ret_trap && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
  end
  pipe_slot #(.W(SW)) u_main (.clk(clk), .rst_n(rst_n), .ld(main_ld), .d(main_d), .q(main_q));
  pipe_slot #(.W(SW)) u_skid (.clk(clk), .rst_n(rst_n), .ld(skid_ld), .d(cap), .q(skid_q));
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign {bus.out_trap, bus.out_we, bus.out_rd, bus.out_res} = main_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.ovf_count = cnt_q;
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: directed vector table plus saturation and async-reset sequences
module tb_ex_mem_skid;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_bad = 0;
  ex_mem_skid_if bus ();
  ex_mem_skid dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [31:0] res; logic ovf, oen; logic [4:0] rd; logic we, fl, ordy, clr;
    logic ev, eir; logic [31:0] eres; logic [4:0] erd; logic ewe, etrap, est; logic [7:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] res, input logic ovf, oen,
                              input logic [4:0] rd, input logic we, fl, ordy, clr,
                              input logic ev, eir, input logic [31:0] eres, input logic [4:0] erd,
                              input logic ewe, etrap, est, input logic [7:0] ecnt);
    vec_t t;
    t.v = v; t.res = res; t.ovf = ovf; t.oen = oen; t.rd = rd; t.we = we; t.fl = fl;
    t.ordy = ordy; t.clr = clr; t.ev = ev; t.eir = eir; t.eres = eres; t.erd = erd;
    t.ewe = ewe; t.etrap = etrap; t.est = est; t.ecnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic ovf, oen,
                       input logic [4:0] rd, input logic we, fl, ordy, clr);
    bus.in_valid = v; bus.in_res = res; bus.in_ovf = ovf; bus.in_ovf_en = oen;
    bus.in_rd = rd; bus.in_we = we; bus.flush = fl; bus.out_ready = ordy; bus.ovf_clr = clr;
  endtask

  vec_t vt[22];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_payload", {bus.out_trap, bus.out_we, bus.out_rd, bus.out_res[24:0]}, 0);
    chk("rst_status", {bus.ovf_sticky, bus.ovf_count}, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    //           v res           ovf oen rd we fl rdy clr | ev ir res           rd we tr st cnt
    vt[0]  = mk(1, 32'h5,         0, 0, 3, 1, 0, 1, 0,   1, 1, 32'h5,         3, 1, 0, 0, 0);
    vt[1]  = mk(0, 32'h0,         0, 0, 0, 0, 0, 1, 0,   0, 1, 32'h0,         0, 0, 0, 0, 0);
    vt[2]  = mk(1, 32'hA,         0, 0, 1, 1, 0, 0, 0,   1, 1, 32'hA,         1, 1, 0, 0, 0);
    vt[3]  = mk(1, 32'hB,         0, 0, 2, 1, 0, 0, 0,   1, 0, 32'hA,         1, 1, 0, 0, 0);
    vt[4]  = mk(1, 32'hC,         0, 0, 4, 1, 0, 0, 0,   1, 0, 32'hA,         1, 1, 0, 0, 0);
    vt[5]  = mk(1, 32'hC,         0, 0, 4, 1, 0, 1, 0,   1, 1, 32'hB,         2, 1, 0, 0, 0);
    vt[6]  = mk(1, 32'hC,         0, 0, 4, 1, 0, 1, 0,   1, 1, 32'hC,         4, 1, 0, 0, 0);
    vt[7]  = mk(0, 32'h0,         0, 0, 0, 0, 0, 1, 0,   0, 1, 32'h0,         0, 0, 0, 0, 0);
    vt[8]  = mk(1, 32'h8000_0000, 1, 0, 5, 1, 0, 1, 0,   1, 1, 32'h8000_0000, 5, 1, 0, 0, 0);
    vt[9]  = mk(1, 32'h8000_0000, 1, 1, 6, 1, 0, 1, 0,   1, 1, 32'h8000_0000, 6, 1, 1, 0, 0);
    vt[10] = mk(1, 32'h7,         0, 0, 0, 1, 0, 1, 0,   1, 1, 32'h7,         0, 0, 0, 1, 1);
    vt[11] = mk(0, 32'h0,         0, 0, 0, 0, 0, 1, 0,   0, 1, 32'h0,         0, 0, 0, 1, 1);
    vt[12] = mk(0, 32'h0,         0, 0, 0, 0, 0, 1, 1,   0, 1, 32'h0,         0, 0, 0, 0, 0);
    vt[13] = mk(1, 32'h11,        0, 0, 1, 1, 0, 0, 0,   1, 1, 32'h11,        1, 1, 0, 0, 0);
    vt[14] = mk(1, 32'h22,        0, 0, 2, 1, 0, 0, 0,   1, 0, 32'h11,        1, 1, 0, 0, 0);
    vt[15] = mk(1, 32'h33,        0, 0, 3, 1, 1, 0, 0,   0, 1, 32'h0,         0, 0, 0, 0, 0);
    vt[16] = mk(0, 32'h0,         0, 0, 0, 0, 0, 1, 0,   0, 1, 32'h0,         0, 0, 0, 0, 0);
    vt[17] = mk(1, 32'h8000_0000, 1, 1, 1, 1, 0, 0, 0,   1, 1, 32'h8000_0000, 1, 1, 1, 0, 0);
    vt[18] = mk(0, 32'h0,         0, 0, 0, 0, 1, 1, 0,   0, 1, 32'h0,         0, 0, 0, 0, 0);
    vt[19] = mk(1, 32'h8000_0000, 1, 1, 7, 1, 0, 1, 0,   1, 1, 32'h8000_0000, 7, 1, 1, 0, 0);
    vt[20] = mk(1, 32'h8000_0000, 1, 1, 8, 1, 0, 1, 0,   1, 1, 32'h8000_0000, 8, 1, 1, 1, 1);
    vt[21] = mk(0, 32'h0,         0, 0, 0, 0, 0, 1, 1,   0, 1, 32'h0,         0, 0, 0, 1, 1);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].res, vt[i].ovf, vt[i].oen, vt[i].rd, vt[i].we, vt[i].fl, vt[i].ordy, vt[i].clr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].ev));
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vt[i].eir));
      chk($sformatf("v%0d_sticky", i), 32'(bus.ovf_sticky), 32'(vt[i].est));
      chk($sformatf("v%0d_count", i), 32'(bus.ovf_count), 32'(vt[i].ecnt));
      if (vt[i].ev) begin
        chk($sformatf("v%0d_res", i), bus.out_res, vt[i].eres);
        chk($sformatf("v%0d_rd", i), 32'(bus.out_rd), 32'(vt[i].erd));
        chk($sformatf("v%0d_we", i), 32'(bus.out_we), 32'(vt[i].ewe));
        chk($sformatf("v%0d_trap", i), 32'(bus.out_trap), 32'(vt[i].etrap));
      end
    end

    // saturation: 256 trapping retires back to back
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk) drive(1, 32'h8000_0000, 1, 1, 9, 1, 0, 1, 0);
      @(posedge clk);
      #1;
      if (k == 255) chk("sat_count_254", 32'(bus.ovf_count), 254);
    end
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("sat_count_255", 32'(bus.ovf_count), 255);
    chk("sat_sticky", 32'(bus.ovf_sticky), 1);
    chk("sat_drained", 32'(bus.out_valid), 0);

    // async reset in the middle of a full buffer
    @(negedge clk) drive(1, 32'h44, 0, 0, 4, 1, 0, 0, 0);
    @(negedge clk) drive(1, 32'h55, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_full", {bus.out_valid, bus.in_ready}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_payload", {bus.out_trap, bus.out_we, bus.out_rd, bus.out_res[24:0]}, 0);
    chk("mid_rst_status", {bus.ovf_sticky, bus.ovf_count}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_empty", {bus.out_valid, bus.in_ready}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
